// File: rtl/mux_alloc.sv
// mux_alloc: packet-level switch allocator for a 2:1 output mux.
// Grants one input port a whole packet (head through tail). Ports 0 and 1
// are arbitrated round-robin per packet. The allocator drives the mux's
// one-hot select and returns ready handshakes to the input ports.
// Optional feature: define MUX_ALLOC_CREDIT_EN to build per-VC downstream
// credit counters, the icredit return path and the sticky err flag.

`ifndef VCHW
`define VCHW 0
`endif
`ifndef PORT
`define PORT 4
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 2'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'd1
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'd3
`endif

module mux_alloc #(
    parameter int VCH          = 2,
    parameter int CREDIT_DEPTH = 4,
    parameter int CNTW         = 3,
    parameter int TYPEW        = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_0,
    input  logic [TYPEW-1:0] itype_1,
    input  logic [`VCHW:0]   ivch_0,
    input  logic [`VCHW:0]   ivch_1,
    output logic             ready_0,
    output logic             ready_1,
    output logic [`PORT:0]   sel,
    input  logic [VCH-1:0]   icredit,
    output logic             busy,
    output logic             err
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [`PORT:0]   sel_q, sel_d;

    logic             own_valid;
    logic [TYPEW-1:0] own_type;
    logic             credit_ok_0, credit_ok_1, credit_ok_own;
    logic             req_0, req_1;
    logic             xfer;

    // Fields of the flit presented by the current owner
    always_comb begin
        own_valid = owner_q ? ivalid_1 : ivalid_0;
        own_type  = owner_q ? itype_1  : itype_0;
    end

`ifdef MUX_ALLOC_CREDIT_EN
    logic [CNTW-1:0]  credit_q [VCH];
    logic [CNTW-1:0]  credit_d [VCH];
    logic             err_q, err_d;
    logic [`VCHW:0]   own_vch;
    logic [VCH-1:0]   dec_vec;

    assign own_vch       = owner_q ? ivch_1 : ivch_0;
    assign credit_ok_0   = (credit_q[ivch_0]  != '0);
    assign credit_ok_1   = (credit_q[ivch_1]  != '0);
    assign credit_ok_own = (credit_q[own_vch] != '0);
    assign err           = err_q;

    // Per-VC credit update: transfer consumes, icredit returns, overflow is sticky
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        err_d   = err_q;
        dec_vec = '0;
        if (xfer) begin
            dec_vec[own_vch] = 1'b1;
        end
        for (int v = 0; v < VCH; v++) begin
            credit_d[v] = credit_q[v];
            if (icredit[v] && !dec_vec[v]) begin
                if (credit_q[v] == CNTW'(CREDIT_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end else if (dec_vec[v] && !icredit[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    // Credit counters and error flag
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            // NOTE: the credit array is a handful of flops, not a RAM, so it is reset to a full window.
            for (int v = 0; v < VCH; v++) begin
                credit_q[v] <= CNTW'(CREDIT_DEPTH);
            end
            err_q <= 1'b0;
        end else begin
            for (int v = 0; v < VCH; v++) begin
                credit_q[v] <= credit_d[v];
            end
            err_q <= err_d;
        end
    end
`else
    logic unused_cfg;

    // Without credit tracking the downstream is assumed always able to accept.
    assign credit_ok_0   = 1'b1;
    assign credit_ok_1   = 1'b1;
    assign credit_ok_own = 1'b1;
    assign err           = 1'b0;
    assign unused_cfg    = ^{icredit, ivch_0, ivch_1} ^ (CNTW != 0) ^ (CREDIT_DEPTH != 0);
`endif

    assign req_0 = ivalid_0 && (itype_0 == TYPEW'(`TYPE_HEAD)) && credit_ok_0;
    assign req_1 = ivalid_1 && (itype_1 == TYPEW'(`TYPE_HEAD)) && credit_ok_1;
    assign xfer  = (state_q == LOCK) && own_valid && credit_ok_own;

    // ready depends only on registered state and credit counters, never on ivalid
    assign ready_0 = (state_q == LOCK) && !owner_q && credit_ok_own;
    assign ready_1 = (state_q == LOCK) &&  owner_q && credit_ok_own;
    assign sel     = sel_q;
    assign busy    = (state_q == LOCK);

    // Next-state: round-robin head arbitration in IDLE, release on tail transfer
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (req_0 || req_1) begin
                    state_d = LOCK;
                    owner_d = (req_0 && req_1) ? ~last_q : req_1;
                    sel_d   = {{(`PORT-1){1'b0}}, owner_d, ~owner_d};
                end
            end
            LOCK: begin
                if (xfer && (own_type == TYPEW'(`TYPE_TAIL))) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    sel_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner, last-granted and select registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            // NOTE: sequential state is written with <= so every flop samples pre-edge values.
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

endmodule
